ps2_key_filter: RTL and testbench



---
 rtl/ps2_key_filter.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_key_filter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_filter.sv
// ps2_key_filter
//   Turns the PS/2 receiver's byte stream into decoded key events. It tracks the
//   make, break (F0) and extended (E0) prefixes. Events whose code is in the
//   accepted key set and whose type (make/break) is enabled are queued in a small
//   first-word-fall-through FIFO for the command decoder downstream.
//
// Parameters
//   FIFO_AW      FIFO address width; depth = 2**FIFO_AW entries
//   REPORT_MAKE  1 = enqueue make events
//   REPORT_BREAK 1 = enqueue break events
//   ACCEPT_ALL   1 = skip the accepted-key table; every non-special code is accepted
//
// Ports
//   CLK       in   system clock, rising edge
//   reset     in   synchronous active-high reset; clears all state
//   tick      in   one-cycle strobe qualifying din
//   din       in   received scan byte
//   rd_en     in   pop the FIFO head; ignored when empty
//   rx_tick   out  one-cycle pulse, the cycle after an event is written
//   dout      out  FIFO head {ext, brk, code}; 10'h000 when empty
//   empty     out  FIFO empty
//   full      out  FIFO full
//   overflow  out  sticky; an accepted event was dropped because the FIFO was full
//   count     out  FIFO occupancy
module ps2_key_filter #(
  parameter int unsigned FIFO_AW      = 2,
  parameter int unsigned REPORT_MAKE  = 0,
  parameter int unsigned REPORT_BREAK = 1,
  parameter int unsigned ACCEPT_ALL   = 0
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               tick,
  input  logic [7:0]         din,
  input  logic               rd_en,
  output logic               rx_tick,
  output logic [9:0]         dout,
  output logic               empty,
  output logic               full,
  output logic               overflow,
  output logic [FIFO_AW:0]   count
);

  localparam int unsigned     Depth    = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

  localparam logic [7:0] CodeExt = 8'hE0;
  localparam logic [7:0] CodeBrk = 8'hF0;

  typedef enum logic [1:0] {StIdle, StExt, StBrk} state_e;

  // ---------------------------------------------------------------------------
  // Byte classification
  // ---------------------------------------------------------------------------
  logic is_ext_pfx;
  logic is_brk_pfx;
  logic is_special;
  logic in_table;
  logic is_accepted;

  assign is_ext_pfx = (din == CodeExt);
  assign is_brk_pfx = (din == CodeBrk);

  // Keyboard responses and error codes; they never form a key event and they
  // abandon any pending prefix.
  assign is_special = din inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF};

  // Digits 1..0, letters H A P I Y N G R, Enter.
  assign in_table = din inside {8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
                                8'h46, 8'h45,
                                8'h33, 8'h1C, 8'h4D, 8'h43, 8'h35, 8'h31, 8'h34, 8'h2D,
                                8'h5A};

  assign is_accepted = (ACCEPT_ALL != 0) || in_table;

  // ---------------------------------------------------------------------------
  // FSM state and event decode
  // ---------------------------------------------------------------------------
  state_e state_q;
  logic   ext_q;

  logic   evt_valid;
  logic   evt_ext;
  logic   evt_brk;
  logic   report_ok;
  logic   evt_want;
  logic   wr_en;
  logic   rd_do;
  logic   drop;
  logic [9:0] evt_data;

  // Any tick that is neither a prefix nor a special code completes an event,
  // whatever state the FSM is in.
  assign evt_valid = tick && !is_ext_pfx && !is_brk_pfx && !is_special;
  assign evt_brk   = (state_q == StBrk);
  assign evt_ext   = (state_q == StExt) || ((state_q == StBrk) && ext_q);
  assign evt_data  = {evt_ext, evt_brk, din};

  assign report_ok = evt_brk ? (REPORT_BREAK != 0) : (REPORT_MAKE != 0);
  assign evt_want  = evt_valid && is_accepted && report_ok;

  // A read in the same cycle frees a slot in a full FIFO.
  assign rd_do = rd_en && !empty;
  assign wr_en = evt_want && (!full || rd_en);
  assign drop  = evt_want && full && !rd_en;

  logic rx_tick_q;
  logic overflow_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      ext_q      <= 1'b0;
      rx_tick_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      rx_tick_q <= wr_en;
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (tick) begin
        unique case (state_q)
          StIdle: begin
            if (is_ext_pfx) begin
              state_q <= StExt;
              ext_q   <= 1'b1;
            end else if (is_brk_pfx) begin
              state_q <= StBrk;
              ext_q   <= 1'b0;
            end else begin
              state_q <= StIdle;
              ext_q   <= 1'b0;
            end
          end
          StExt: begin
            if (is_brk_pfx) begin
              state_q <= StBrk;
            end else if (is_ext_pfx) begin
              state_q <= StExt;
            end else begin
              state_q <= StIdle;
              ext_q   <= 1'b0;
            end
          end
          StBrk: begin
            if (is_brk_pfx) begin
              state_q <= StBrk;
            end else if (is_ext_pfx) begin
              // A fresh E0 after F0 means the stream resynchronised on a new key.
              state_q <= StExt;
              ext_q   <= 1'b1;
            end else begin
              state_q <= StIdle;
              ext_q   <= 1'b0;
            end
          end
          default: begin
            state_q <= StIdle;
            ext_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // First-word-fall-through FIFO
  // ---------------------------------------------------------------------------
  logic [9:0]         mem_q [Depth];
  logic [FIFO_AW-1:0] wr_ptr_q;
  logic [FIFO_AW-1:0] rd_ptr_q;
  logic [FIFO_AW:0]   count_q;

  // Storage has no reset; only the pointers and occupancy define what is valid.
  always_ff @(posedge CLK) begin
    if (!reset && wr_en) begin
      mem_q[wr_ptr_q] <= evt_data;
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_do) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({wr_en, rd_do})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == DepthCnt);
  assign count    = count_q;
  assign dout     = empty ? 10'h000 : mem_q[rd_ptr_q];
  assign rx_tick  = rx_tick_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ps2_key_filter.sv
// Bench for ps2_key_filter. Three instances share tick/din/reset:
//   u0 defaults (break only), u1 make only, u2 break only with ACCEPT_ALL.
// Stimulus pushes the hand-computed event each instance should write into a
// per-instance expectation queue; a negedge monitor pops it on rx_tick, keeps a
// reference FIFO and compares every output each cycle.
module tb_ps2_key_filter;

  logic       CLK = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] din = 8'h00;
  logic [2:0] rd_en = 3'b000;

  logic [2:0] rx_tick;
  logic [2:0] empty;
  logic [2:0] full;
  logic [2:0] overflow;
  logic [9:0] dout  [3];
  logic [2:0] count [3];

  always #5 CLK = ~CLK;

  ps2_key_filter #(.FIFO_AW(2), .REPORT_MAKE(0), .REPORT_BREAK(1), .ACCEPT_ALL(0)) u0 (
    .CLK(CLK), .reset(reset), .tick(tick), .din(din), .rd_en(rd_en[0]),
    .rx_tick(rx_tick[0]), .dout(dout[0]), .empty(empty[0]), .full(full[0]),
    .overflow(overflow[0]), .count(count[0])
  );

  ps2_key_filter #(.FIFO_AW(2), .REPORT_MAKE(1), .REPORT_BREAK(0), .ACCEPT_ALL(0)) u1 (
    .CLK(CLK), .reset(reset), .tick(tick), .din(din), .rd_en(rd_en[1]),
    .rx_tick(rx_tick[1]), .dout(dout[1]), .empty(empty[1]), .full(full[1]),
    .overflow(overflow[1]), .count(count[1])
  );

  ps2_key_filter #(.FIFO_AW(2), .REPORT_MAKE(0), .REPORT_BREAK(1), .ACCEPT_ALL(1)) u2 (
    .CLK(CLK), .reset(reset), .tick(tick), .din(din), .rd_en(rd_en[2]),
    .rx_tick(rx_tick[2]), .dout(dout[2]), .empty(empty[2]), .full(full[2]),
    .overflow(overflow[2]), .count(count[2])
  );

  // Scoreboard state
  logic [9:0] exp_q [3][$];
  logic [9:0] mf    [3][$];
  logic [2:0] exp_ovf = 3'b000;
  logic [2:0] rd_s = 3'b000;
  logic       rst_s = 1'b0;
  logic       armed = 1'b0;
  logic [9:0] hd;
  int         n_total = 0;
  int         n_pass = 0;

  localparam logic [10:0] NO = 11'h000;

  function automatic logic [10:0] ev(input logic [9:0] v);
    return {1'b1, v};
  endfunction

  task automatic chk(input int i, input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL u%0d %s: got %0h want %0h (t=%0t)", i, nm, got, want, $time);
  endtask

  always @(posedge CLK) begin
    rd_s  <= rd_en;
    rst_s <= reset;
  end

  always @(negedge CLK) begin
    if (armed) begin
      for (int i = 0; i < 3; i++) begin
        if (rst_s) begin
          mf[i].delete();
          exp_q[i].delete();
        end else if (rd_s[i] && mf[i].size() > 0) begin
          void'(mf[i].pop_front());
        end
        chk(i, "rx_tick", {31'b0, rx_tick[i]}, (exp_q[i].size() > 0) ? 32'd1 : 32'd0);
        if (rx_tick[i] === 1'b1 && exp_q[i].size() > 0) mf[i].push_back(exp_q[i].pop_front());
        exp_q[i].delete();
        hd = (mf[i].size() > 0) ? mf[i][0] : 10'h000;
        chk(i, "dout", {22'b0, dout[i]}, {22'b0, hd});
        chk(i, "count", {29'b0, count[i]}, 32'(mf[i].size()));
        chk(i, "empty", {31'b0, empty[i]}, (mf[i].size() == 0) ? 32'd1 : 32'd0);
        chk(i, "full", {31'b0, full[i]}, (mf[i].size() == 4) ? 32'd1 : 32'd0);
        chk(i, "overflow", {31'b0, overflow[i]}, {31'b0, exp_ovf[i]});
      end
    end
  end

  // One byte tick (optionally with reads); x* are the events each instance writes.
  task automatic send(input logic [7:0] b, input logic [2:0] rd,
                      input logic [10:0] x0, input logic [10:0] x1, input logic [10:0] x2);
    tick  = 1'b1;
    din   = b;
    rd_en = rd;
    @(posedge CLK);
    #1;
    tick  = 1'b0;
    rd_en = 3'b000;
    if (x0[10]) exp_q[0].push_back(x0[9:0]);
    if (x1[10]) exp_q[1].push_back(x1[9:0]);
    if (x2[10]) exp_q[2].push_back(x2[9:0]);
  endtask

  task automatic pop(input logic [2:0] rd);
    rd_en = rd;
    @(posedge CLK);
    #1;
    rd_en = 3'b000;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Reset with competing tick/rd_en to show reset wins.
  task automatic do_reset(input logic tk, input logic [7:0] d, input logic [2:0] rd);
    reset = 1'b1;
    tick  = tk;
    din   = d;
    rd_en = rd;
    @(posedge CLK);
    #1;
    reset   = 1'b0;
    tick    = 1'b0;
    rd_en   = 3'b000;
    exp_ovf = 3'b000;
  endtask

  logic [7:0] fill_codes [5];

  initial begin
    fill_codes[0] = 8'h16; fill_codes[1] = 8'h1E; fill_codes[2] = 8'h26;
    fill_codes[3] = 8'h25; fill_codes[4] = 8'h2E;

    @(posedge CLK);
    #1;
    do_reset(1'b0, 8'h00, 3'b000);
    armed = 1'b1;
    idle(1);

    // Plain break of '1'
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'h16, 3'b000, ev(10'h116), NO, ev(10'h116));
    idle(1);
    pop(3'b111);

    // Extended break / extended make of Enter
    send(8'hE0, 3'b000, NO, NO, NO);
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'h5A, 3'b000, ev(10'h35A), NO, ev(10'h35A));
    send(8'hE0, 3'b000, NO, NO, NO);
    send(8'h5A, 3'b000, NO, ev(10'h25A), NO);
    pop(3'b111);

    // Make then break of 'A'
    send(8'h1C, 3'b000, NO, ev(10'h01C), NO);
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'h1C, 3'b000, ev(10'h11C), NO, ev(10'h11C));
    pop(3'b111);

    // Unlisted key, then a special code cancelling a break prefix
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'h15, 3'b000, NO, NO, ev(10'h115));
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'hAA, 3'b000, NO, NO, NO);
    send(8'h16, 3'b000, NO, ev(10'h016), NO);
    pop(3'b111);

    // Special code cancelling an extended prefix; E0 E0 repeat; F0 E0 resync
    send(8'hE0, 3'b000, NO, NO, NO);
    send(8'hFA, 3'b000, NO, NO, NO);
    send(8'h1C, 3'b000, NO, ev(10'h01C), NO);
    send(8'hE0, 3'b000, NO, NO, NO);
    send(8'hE0, 3'b000, NO, NO, NO);
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'h1E, 3'b000, ev(10'h31E), NO, ev(10'h31E));
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'hE0, 3'b000, NO, NO, NO);
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'h5A, 3'b000, ev(10'h35A), NO, ev(10'h35A));
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'hE0, 3'b000, NO, NO, NO);
    send(8'h5A, 3'b000, NO, ev(10'h25A), NO);
    pop(3'b111);
    pop(3'b111);
    pop(3'b111);

    // Fill to full, then write with a same-cycle read, then drop one
    for (int k = 0; k < 4; k++) begin
      send(8'hF0, 3'b000, NO, NO, NO);
      send(fill_codes[k], 3'b000, ev({2'b01, fill_codes[k]}), NO, ev({2'b01, fill_codes[k]}));
    end
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'h2E, 3'b111, ev(10'h12E), NO, ev(10'h12E));
    idle(1);
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'h36, 3'b000, NO, NO, NO);
    exp_ovf = 3'b101;
    idle(2);
    for (int k = 0; k < 5; k++) pop(3'b111);

    // Reset between F0 and the key, with a live tick and rd_en in the reset cycle
    send(8'hF0, 3'b000, NO, NO, NO);
    send(8'h16, 3'b000, ev(10'h116), NO, ev(10'h116));
    send(8'hF0, 3'b000, NO, NO, NO);
    do_reset(1'b1, 8'h5A, 3'b111);
    send(8'h16, 3'b000, NO, ev(10'h016), NO);
    pop(3'b111);

    // Five breaks with no reads: the fifth is dropped
    for (int k = 0; k < 5; k++) begin
      send(8'hF0, 3'b000, NO, NO, NO);
      if (k < 4) send(fill_codes[k], 3'b000, ev({2'b01, fill_codes[k]}), NO,
                      ev({2'b01, fill_codes[k]}));
      else       send(fill_codes[k], 3'b000, NO, NO, NO);
    end
    exp_ovf = 3'b101;
    idle(1);
    for (int k = 0; k < 4; k++) pop(3'b111);
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
